// File: rtl/uctl_ahb_mstr_pkg.sv
// rtl/uctl_ahb_mstr_pkg.sv - AHB transfer codes and FSM encodings shared by the burst engine
package uctl_ahb_mstr_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'b000,
        BURST_INCR   = 3'b001,
        BURST_INCR16 = 3'b111
    } hburst_e;

    typedef enum logic [2:0] {
        SIZE_BYTES = 3'b000,
        SIZE_HWORD = 3'b001,
        SIZE_WORD  = 3'b010
    } hsize_e;

    typedef enum logic [1:0] {
        RESP_OKAY  = 2'b00,
        RESP_ERROR = 2'b01,
        RESP_RETRY = 2'b10,
        RESP_SPLIT = 2'b11
    } hresp_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10
    } mstrState_e;

    localparam logic [4:0] MAX_BEATS = 5'd16;

    // Unsupported sizes fall back to word stepping
    function automatic logic [2:0] beatIncr(input logic [2:0] hSize);
        case (hSize)
            SIZE_BYTES: beatIncr = 3'd1;
            SIZE_HWORD: beatIncr = 3'd2;
            default:    beatIncr = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/uctl_ahb_addrGen.sv
// rtl/uctl_ahb_addrGen.sv - next-beat address, 1 KB crossing detect and HBURST selection
module uctl_ahb_addrGen
    import uctl_ahb_mstr_pkg::*;
#(
    parameter int ADDR_SIZE = 32,
    parameter int KB_BITS   = 10
) (
    input  logic [ADDR_SIZE-1:0] curAddr,
    input  logic [2:0]           curSize,
    input  logic [ADDR_SIZE-1:0] reqAddr,
    input  logic [2:0]           reqSize,
    input  logic [4:0]           reqBeats,
    output logic [ADDR_SIZE-1:0] nextAddr,
    output logic                 crossNext,
    output logic [ADDR_SIZE-1:0] reqEndAddr,
    output logic [2:0]           reqBurst
);

    logic [ADDR_SIZE-1:0] reqSpan;
    logic [ADDR_SIZE-1:0] reqLastAddr;
    logic                 reqCross;

    always_comb begin
        nextAddr    = curAddr + ADDR_SIZE'(beatIncr(curSize));
        crossNext   = nextAddr[ADDR_SIZE-1:KB_BITS] != curAddr[ADDR_SIZE-1:KB_BITS];
        reqSpan     = ADDR_SIZE'(reqBeats) * ADDR_SIZE'(beatIncr(reqSize));
        reqEndAddr  = reqAddr + reqSpan;
        reqLastAddr = reqEndAddr - ADDR_SIZE'(1);
        // A fixed-length burst may not straddle the boundary, so such bursts run as INCR
        reqCross    = reqLastAddr[ADDR_SIZE-1:KB_BITS] != reqAddr[ADDR_SIZE-1:KB_BITS];
        reqBurst    = (reqBeats == MAX_BEATS && !reqCross) ? BURST_INCR16 : BURST_INCR;
    end

endmodule

// File: rtl/uctl_ahb_mstr.sv
// rtl/uctl_ahb_mstr.sv - AHB burst master between burst shaper and endpoint FIFO; option UCTL_AHB_RESP_EN
module uctl_ahb_mstr
    import uctl_ahb_mstr_pkg::*;
#(
    parameter int ADDR_SIZE = 32,
    parameter int DATA_SIZE = 32,
    parameter int KB_BITS   = 10
) (
    input  logic                 uctl_sysClk,
    input  logic                 uctl_sysRst,
    input  logic                 ctrl2ahbc_trEn,
    input  logic [4:0]           ctrl2ahbc_beats,
    input  logic [2:0]           ctrl2ahbc_hSize,
    input  logic [ADDR_SIZE-1:0] ctrl2ahbc_sRdAddr,
    input  logic                 ctrl2ahbc_sRdWr,
    output logic                 ahbc2ctrl_ack,
    output logic                 ahbc2ctrl_addrDn,
    output logic                 ahbc2ctrl_dataDn,
    output logic [ADDR_SIZE-1:0] ahbc2ctrl_sWrAddr,
`ifdef UCTL_AHB_RESP_EN
    output logic                 ahbc2ctrl_err,
`endif
    output logic                 fifo_wrEn,
    output logic [DATA_SIZE-1:0] fifo_wrData,
    output logic                 fifo_rdEn,
    input  logic [DATA_SIZE-1:0] fifo_rdData,
    input  logic                 fifo_empty,
    output logic [1:0]           HTRANS,
    output logic [2:0]           HBURST,
    output logic [2:0]           HSIZE,
    output logic [ADDR_SIZE-1:0] HADDR,
    output logic                 HWRITE,
    output logic [DATA_SIZE-1:0] HWDATA,
    input  logic [DATA_SIZE-1:0] HRDATA,
    input  logic                 HREADY,
    input  logic [1:0]           HRESP
);

    mstrState_e           state, stateNxt;
    htrans_e              transCur;
    logic [ADDR_SIZE-1:0] curAddr, endAddr, nextAddr, reqEndAddr;
    logic [4:0]           addrLeft, reqBeats;
    logic [2:0]           sizeReg, burstReg, reqBurst;
    logic                 writeReg, needNonseq, crossNext, dataPending;
    logic [DATA_SIZE-1:0] wdataReg;
    logic                 reqTake, addrAccept, lastAddr, addrDnNxt, dataDnNxt;
    logic                 errHold, errAbort, errData;

    assign reqBeats = (ctrl2ahbc_beats > MAX_BEATS) ? MAX_BEATS : ctrl2ahbc_beats;
    assign reqTake  = (state == ST_IDLE) && ctrl2ahbc_trEn;

    uctl_ahb_addrGen #(
        .ADDR_SIZE (ADDR_SIZE),
        .KB_BITS   (KB_BITS)
    ) u_addrGen (
        .curAddr    (curAddr),
        .curSize    (sizeReg),
        .reqAddr    (ctrl2ahbc_sRdAddr),
        .reqSize    (ctrl2ahbc_hSize),
        .reqBeats   (reqBeats),
        .nextAddr   (nextAddr),
        .crossNext  (crossNext),
        .reqEndAddr (reqEndAddr),
        .reqBurst   (reqBurst)
    );

`ifdef UCTL_AHB_RESP_EN
    logic errSeen, errLatch;

    // First ERROR cycle has HREADY low; the bus is idled on the second one
    assign errData  = dataPending && (HRESP == RESP_ERROR);
    assign errHold  = errSeen;
    assign errAbort = errSeen && HREADY;
    assign ahbc2ctrl_err = ahbc2ctrl_dataDn && errLatch;

    always_ff @(posedge uctl_sysClk or posedge uctl_sysRst) begin
        if (uctl_sysRst) begin
            errSeen  <= 1'b0;
            errLatch <= 1'b0;
        end else begin
            errSeen <= errData && !HREADY;
            if (reqTake)
                errLatch <= 1'b0;
            else if (errAbort)
                errLatch <= 1'b1;
        end
    end
`else
    logic unusedHresp;
    assign unusedHresp = ^HRESP;
    assign errData     = 1'b0;
    assign errHold     = 1'b0;
    assign errAbort    = 1'b0;
`endif

    // BUSY is only legal inside a burst, so a starved NONSEQ beat waits as IDLE
    always_comb begin
        transCur = TRANS_IDLE;
        if (state == ST_ADDR && addrLeft != 5'd0 && !errHold) begin
            if (writeReg && fifo_empty)
                transCur = needNonseq ? TRANS_IDLE : TRANS_BUSY;
            else
                transCur = needNonseq ? TRANS_NONSEQ : TRANS_SEQ;
        end
    end

    assign addrAccept = HREADY && (transCur == TRANS_NONSEQ || transCur == TRANS_SEQ);
    assign lastAddr   = addrAccept && (addrLeft == 5'd1);

    always_comb begin
        stateNxt  = state;
        addrDnNxt = 1'b0;
        dataDnNxt = 1'b0;
        case (state)
            ST_IDLE: if (ctrl2ahbc_trEn) stateNxt = ST_ADDR;
            ST_ADDR: begin
                if (lastAddr || addrLeft == 5'd0 || errAbort) begin
                    stateNxt  = ST_DATA;
                    addrDnNxt = 1'b1;
                end
            end
            ST_DATA: begin
                if (!dataPending || HREADY) begin
                    stateNxt  = ST_IDLE;
                    dataDnNxt = 1'b1;
                end
            end
            default: stateNxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge uctl_sysClk or posedge uctl_sysRst) begin
        if (uctl_sysRst) begin
            state             <= ST_IDLE;
            curAddr           <= '0;
            endAddr           <= '0;
            addrLeft          <= 5'd0;
            sizeReg           <= SIZE_BYTES;
            burstReg          <= BURST_SINGLE;
            writeReg          <= 1'b0;
            needNonseq        <= 1'b0;
            dataPending       <= 1'b0;
            wdataReg          <= '0;
            ahbc2ctrl_ack     <= 1'b0;
            ahbc2ctrl_addrDn  <= 1'b0;
            ahbc2ctrl_dataDn  <= 1'b0;
            ahbc2ctrl_sWrAddr <= '0;
        end else begin
            state            <= stateNxt;
            ahbc2ctrl_ack    <= reqTake;
            ahbc2ctrl_addrDn <= addrDnNxt;
            ahbc2ctrl_dataDn <= dataDnNxt;
            dataPending      <= addrAccept || (dataPending && !HREADY);
            if (reqTake) begin
                curAddr    <= ctrl2ahbc_sRdAddr;
                endAddr    <= reqEndAddr;
                addrLeft   <= reqBeats;
                sizeReg    <= ctrl2ahbc_hSize;
                burstReg   <= reqBurst;
                writeReg   <= ctrl2ahbc_sRdWr;
                needNonseq <= 1'b1;
            end else if (addrAccept) begin
                curAddr    <= nextAddr;
                addrLeft   <= addrLeft - 5'd1;
                needNonseq <= crossNext;
            end else if (errAbort) begin
                addrLeft   <= 5'd0;
            end
            if (addrDnNxt)
                ahbc2ctrl_sWrAddr <= endAddr;
            if (fifo_rdEn)
                wdataReg <= fifo_rdData;
        end
    end

    assign HTRANS      = transCur;
    assign HBURST      = burstReg;
    assign HSIZE       = sizeReg;
    assign HADDR       = curAddr;
    assign HWRITE      = writeReg;
    assign HWDATA      = wdataReg;
    assign fifo_wrEn   = dataPending && HREADY && !writeReg && !errData;
    assign fifo_wrData = HRDATA;
    assign fifo_rdEn   = addrAccept && writeReg;

endmodule

// File: tb/tb_uctl_ahb_mstr.sv
// tb/tb_uctl_ahb_mstr.sv - directed bench for the AHB burst master
module tb_uctl_ahb_mstr;

    logic        clk = 1'b0;
    logic        rst;
    logic        trEn;
    logic [4:0]  beats;
    logic [2:0]  hSize;
    logic [31:0] sRdAddr;
    logic        sRdWr;
    logic        ack, addrDn, dataDn;
    logic [31:0] sWrAddr;
    logic        fifoWrEn, fifoRdEn, fifoEmpty;
    logic [31:0] fifoWrData, fifoRdData;
    logic [1:0]  htrans, hresp;
    logic [2:0]  hburst, hsizeOut;
    logic [31:0] haddr, hwdata, hrdata;
    logic        hwrite, hready;
`ifdef UCTL_AHB_RESP_EN
    logic        err;
`endif

    int passCount = 0;
    int checkCount = 0;
    int failCount = 0;

    int          ackCyc, addrDnCyc, dataDnCyc, errCyc;
    int          nAcc, nWr, nRd, nBusy, wrDataBad;
    logic [31:0] accAddr [32];
    logic [1:0]  accTr [32];
    logic [31:0] wdSeen [32];
    logic [31:0] sWrSeen;
    logic [2:0]  burstSeen;
    logic [1:0]  errTr;
    logic [31:0] fifoQ [$];

    always #5 clk = ~clk;

    uctl_ahb_mstr #(.ADDR_SIZE(32), .DATA_SIZE(32), .KB_BITS(10)) dut (
        .uctl_sysClk       (clk),
        .uctl_sysRst       (rst),
        .ctrl2ahbc_trEn    (trEn),
        .ctrl2ahbc_beats   (beats),
        .ctrl2ahbc_hSize   (hSize),
        .ctrl2ahbc_sRdAddr (sRdAddr),
        .ctrl2ahbc_sRdWr   (sRdWr),
        .ahbc2ctrl_ack     (ack),
        .ahbc2ctrl_addrDn  (addrDn),
        .ahbc2ctrl_dataDn  (dataDn),
        .ahbc2ctrl_sWrAddr (sWrAddr),
`ifdef UCTL_AHB_RESP_EN
        .ahbc2ctrl_err     (err),
`endif
        .fifo_wrEn         (fifoWrEn),
        .fifo_wrData       (fifoWrData),
        .fifo_rdEn         (fifoRdEn),
        .fifo_rdData       (fifoRdData),
        .fifo_empty        (fifoEmpty),
        .HTRANS            (htrans),
        .HBURST            (hburst),
        .HSIZE             (hsizeOut),
        .HADDR             (haddr),
        .HWRITE            (hwrite),
        .HWDATA            (hwdata),
        .HRDATA            (hrdata),
        .HREADY            (hready),
        .HRESP             (hresp)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) begin
            passCount++;
        end else begin
            failCount++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one request from a negedge and records bus activity until dataDn (or an early stop)
    task automatic runBurst(input logic rw, input logic [4:0] nb, input logic [2:0] sz,
                            input logic [31:0] addr, input bit rndReady, input int rstAt,
                            input int errBeat);
        int  cyc, errPh, nDone, emptyLeft;
        bit  pend, acc, emptyDone;
        ackCyc = -1; addrDnCyc = -1; dataDnCyc = -1; errCyc = -1;
        nAcc = 0; nWr = 0; nRd = 0; nBusy = 0; wrDataBad = 0;
        sWrSeen = 32'hDEAD_BEEF; burstSeen = 3'b010; errTr = 2'b11;
        cyc = 0; errPh = 0; nDone = 0; emptyLeft = 0; pend = 1'b0; emptyDone = 1'b0;
        trEn = 1'b1; beats = nb; hSize = sz; sRdAddr = addr; sRdWr = rw;
        while (cyc < 300) begin
            hresp  = 2'b00;
            hready = rndReady ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (errBeat != 0 && pend && nDone == errBeat - 1 && errPh == 0) errPh = 1;
            if (errPh == 1) begin hready = 1'b0; hresp = 2'b01; end
            else if (errPh == 2) begin hready = 1'b1; hresp = 2'b01; end
            if (rw && nRd == 2 && !emptyDone) begin emptyLeft = 2; emptyDone = 1'b1; end
            fifoEmpty  = (fifoQ.size() == 0) || (emptyLeft > 0);
            fifoRdData = (fifoQ.size() != 0) ? fifoQ[0] : 32'h0;
            hrdata     = 32'hC0DE_0000 + 32'(cyc);
            #1;
            if (cyc == 1) burstSeen = hburst;
            if (ack) ackCyc = cyc;
            if (addrDn) begin addrDnCyc = cyc; sWrSeen = sWrAddr; end
            if (errPh == 2) errTr = htrans;
`ifdef UCTL_AHB_RESP_EN
            if (err) errCyc = cyc;
`endif
            if (fifoWrEn) begin
                nWr++;
                if (fifoWrData !== hrdata) wrDataBad++;
            end
            if (fifoRdEn) begin nRd++; void'(fifoQ.pop_front()); end
            if (htrans == 2'b01) nBusy++;
            if (pend && hready) begin
                if (nDone < 32) wdSeen[nDone] = hwdata;
                nDone++;
            end
            acc = hready && (htrans == 2'b10 || htrans == 2'b11);
            if (acc && nAcc < 32) begin accAddr[nAcc] = haddr; accTr[nAcc] = htrans; end
            if (acc) nAcc++;
            if (hready) pend = acc;
            if (emptyLeft > 0) emptyLeft--;
            if (errPh == 1 || errPh == 2) errPh++;
            if (dataDn) begin dataDnCyc = cyc; break; end
            if (rstAt != 0 && nAcc == rstAt) break;
            @(negedge clk);
            trEn = 1'b0;
            cyc++;
        end
        trEn = 1'b0; hready = 1'b1; hresp = 2'b00;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; trEn = 1'b0; beats = 5'd0; hSize = 3'd0; sRdAddr = 32'h0; sRdWr = 1'b0;
        fifoRdData = 32'h0; fifoEmpty = 1'b1; hrdata = 32'h0; hready = 1'b1; hresp = 2'b00;
        @(negedge clk); @(negedge clk); #1;
        check("rst_htrans", {30'd0, htrans}, 32'h0);
        check("rst_haddr", haddr, 32'h0);
        check("rst_hburst", {29'd0, hburst}, 32'h0);
        check("rst_hwrite", {31'd0, hwrite}, 32'h0);
        check("rst_pulses", {29'd0, ack, addrDn, dataDn}, 32'h0);
        check("rst_swraddr", sWrAddr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 16-word aligned read: INCR16
        runBurst(1'b0, 5'd16, 3'b010, 32'h0000_1000, 1'b0, 0, 0);
        check("t1_ack_cyc", ackCyc, 1);
        check("t1_hburst", {29'd0, burstSeen}, 32'h7);
        check("t1_first_trans", {30'd0, accTr[0]}, 32'h2);
        check("t1_second_trans", {30'd0, accTr[1]}, 32'h3);
        check("t1_last_addr", accAddr[15], 32'h0000_103C);
        check("t1_wren_count", nWr, 16);
        check("t1_rd_passthru", wrDataBad, 0);
        check("t1_addrdn_cyc", addrDnCyc, 17);
        check("t1_swraddr", sWrSeen, 32'h0000_1040);
        check("t1_datadn_cyc", dataDnCyc, 18);

        // 16-word read crossing 1 KB at beat 4
        runBurst(1'b0, 5'd16, 3'b010, 32'h0000_13F0, 1'b0, 0, 0);
        check("t2_hburst", {29'd0, burstSeen}, 32'h1);
        check("t2_cross_addr", accAddr[4], 32'h0000_1400);
        check("t2_cross_trans", {30'd0, accTr[4]}, 32'h2);
        check("t2_after_trans", {30'd0, accTr[5]}, 32'h3);
        check("t2_before_trans", {30'd0, accTr[3]}, 32'h3);
        check("t2_swraddr", sWrSeen, 32'h0000_1430);
        check("t2_wren_count", nWr, 16);

        // byte read with random wait states
        runBurst(1'b0, 5'd3, 3'b000, 32'h0000_2001, 1'b1, 0, 0);
        check("t3_datadn_seen", {31'd0, dataDnCyc >= 0}, 32'h1);
        check("t3_ack_cyc", ackCyc, 1);
        check("t3_addr0", accAddr[0], 32'h0000_2001);
        check("t3_addr1", accAddr[1], 32'h0000_2002);
        check("t3_addr2", accAddr[2], 32'h0000_2003);
        check("t3_acc_count", nAcc, 3);
        check("t3_wren_count", nWr, 3);
        check("t3_swraddr", sWrSeen, 32'h0000_2004);

        // 4-word write with the FIFO starved for two cycles after two pops
        fifoQ = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        runBurst(1'b1, 5'd4, 3'b010, 32'h0000_3000, 1'b0, 0, 0);
        check("t4_busy_count", nBusy, 2);
        check("t4_rden_count", nRd, 4);
        check("t4_addr2", accAddr[2], 32'h0000_3008);
        check("t4_trans2", {30'd0, accTr[2]}, 32'h3);
        check("t4_hwdata0", wdSeen[0], 32'h1111_1111);
        check("t4_hwdata1", wdSeen[1], 32'h2222_2222);
        check("t4_hwdata2", wdSeen[2], 32'h3333_3333);
        check("t4_hwdata3", wdSeen[3], 32'h4444_4444);
        check("t4_swraddr", sWrSeen, 32'h0000_3010);
        check("t4_datadn_cyc", dataDnCyc, 8);

        // zero-beat request: pulses only
        runBurst(1'b0, 5'd0, 3'b010, 32'h0000_6000, 1'b0, 0, 0);
        check("t0_ack_cyc", ackCyc, 1);
        check("t0_addrdn_cyc", addrDnCyc, 2);
        check("t0_datadn_cyc", dataDnCyc, 3);
        check("t0_no_traffic", nAcc, 0);
        check("t0_swraddr", sWrSeen, 32'h0000_6000);

        // beats above 16 clamp to 16
        runBurst(1'b0, 5'd20, 3'b000, 32'h0000_7000, 1'b0, 0, 0);
        check("tc_acc_count", nAcc, 16);
        check("tc_hburst", {29'd0, burstSeen}, 32'h7);
        check("tc_swraddr", sWrSeen, 32'h0000_7010);

        // halfword read
        runBurst(1'b0, 5'd2, 3'b001, 32'h0000_8000, 1'b0, 0, 0);
        check("th_addr1", accAddr[1], 32'h0000_8002);
        check("th_hburst", {29'd0, burstSeen}, 32'h1);
        check("th_swraddr", sWrSeen, 32'h0000_8004);

        // reset while beat 7 of a 16-beat read is on the bus
        runBurst(1'b0, 5'd16, 3'b010, 32'h0000_4000, 1'b0, 7, 0);
        rst = 1'b1;
        #1;
        check("t5_htrans", {30'd0, htrans}, 32'h0);
        check("t5_pulses", {29'd0, ack, addrDn, dataDn}, 32'h0);
        check("t5_wren", {31'd0, fifoWrEn}, 32'h0);
        check("t5_haddr", haddr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        runBurst(1'b0, 5'd4, 3'b010, 32'h0000_5000, 1'b0, 0, 0);
        check("t5_ack_cyc", ackCyc, 1);
        check("t5_wren_count", nWr, 4);
        check("t5_addrdn_cyc", addrDnCyc, 5);
        check("t5_datadn_cyc", dataDnCyc, 6);
        check("t5_swraddr", sWrSeen, 32'h0000_5010);

`ifdef UCTL_AHB_RESP_EN
        // ERROR response on beat 2 of 8
        runBurst(1'b0, 5'd8, 3'b010, 32'h0000_9000, 1'b0, 0, 2);
        check("t6_idle_2nd_err", {30'd0, errTr}, 32'h0);
        check("t6_acc_count", nAcc, 2);
        check("t6_wren_count", nWr, 1);
        check("t6_addrdn_cyc", addrDnCyc, 5);
        check("t6_datadn_cyc", dataDnCyc, 6);
        check("t6_err_cyc", errCyc, 6);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
